// File: rtl/ptw_mem_responder_pkg.sv
// Shared encodings for the page-table-walk memory responder: FSM states and
// requester identifiers used by the arbiter and the top-level FSM.
package ptw_mem_responder_pkg;

  typedef enum logic [1:0] {
    PTW_ST_IDLE = 2'd0,
    PTW_ST_ADDR = 2'd1,
    PTW_ST_DATA = 2'd2,
    PTW_ST_RESP = 2'd3
  } ptw_state_e;

  // Requester identifiers; also the bit positions in the one-hot grant.
  localparam logic PTW_GNT_IF = 1'b0;
  localparam logic PTW_GNT_LS = 1'b1;

endpackage

// File: rtl/ptw_mem_responder_rr_arbiter.sv
// Two-input round-robin arbiter: on a tie the requester that was not granted
// last wins; a lone requester always wins. Grant is one-hot, indexed by PTW_GNT_*.
module ptw_rr_arbiter
  import ptw_mem_responder_pkg::*;
(
  input  logic       req_if_i,
  input  logic       req_ls_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (req_if_i && req_ls_i) begin
      if (last_grant_i == PTW_GNT_LS) gnt_o[PTW_GNT_IF] = 1'b1;
      else                            gnt_o[PTW_GNT_LS] = 1'b1;
    end else if (req_if_i) begin
      gnt_o[PTW_GNT_IF] = 1'b1;
    end else if (req_ls_i) begin
      gnt_o[PTW_GNT_LS] = 1'b1;
    end
  end

endmodule

// File: rtl/ptw_mem_responder.sv
// Serves PTE reads for the IFU and LSU page-table walkers over one single-beat
// read channel, one transaction at a time, with a bus timeout that forces a fault.
module ptw_mem_responder
  import ptw_mem_responder_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_mem_req_i,
  input  logic [ADDR_W-1:0] if_mem_addr_i,
  output logic [DATA_W-1:0] if_mem_rdata_o,
  output logic              if_mem_rvalid_o,
  output logic              if_mem_fault_o,
  input  logic              ls_mem_req_i,
  input  logic [ADDR_W-1:0] ls_mem_addr_i,
  output logic [DATA_W-1:0] ls_mem_rdata_o,
  output logic              ls_mem_rvalid_o,
  output logic              ls_mem_fault_o,
  output logic              rd_req_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  logic              rd_ready_i,
  input  logic              rd_valid_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              rd_err_i,
  output logic [1:0]        dbg_state_o
);

  // Handshakes: walkers hold req (and a stable addr) until their one-cycle
  // rvalid; the address transfers on rd_req_o && rd_ready_i; read data is taken
  // on rd_valid_i only while waiting for it, and ignored in every other state.

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  ptw_state_e        state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;

  logic [1:0]        arb_gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic              timeout;
  logic              gnt_req;

  ptw_rr_arbiter u_arb (
    .req_if_i     (if_mem_req_i),
    .req_ls_i     (ls_mem_req_i),
    .last_grant_i (last_grant_q),
    .gnt_o        (arb_gnt)
  );

  // cnt_q holds the cycles already spent in ADDR/DATA, so this is the last one.
  assign timeout     = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign sel_addr    = arb_gnt[PTW_GNT_LS] ? ls_mem_addr_i : if_mem_addr_i;
  assign gnt_req     = (gnt_q == PTW_GNT_LS) ? ls_mem_req_i : if_mem_req_i;
  assign dbg_state_o = state_q;

  always_comb begin
    state_d         = state_q;
    gnt_d           = gnt_q;
    last_grant_d    = last_grant_q;
    cnt_d           = cnt_q;
    addr_d          = addr_q;
    data_d          = data_q;
    err_d           = err_q;
    rd_req_o        = 1'b0;
    rd_addr_o       = '0;
    if_mem_rvalid_o = 1'b0;
    if_mem_rdata_o  = '0;
    if_mem_fault_o  = 1'b0;
    ls_mem_rvalid_o = 1'b0;
    ls_mem_rdata_o  = '0;
    ls_mem_fault_o  = 1'b0;

    case (state_q)
      PTW_ST_IDLE: begin
        if (|arb_gnt) begin
          gnt_d   = arb_gnt[PTW_GNT_LS] ? PTW_GNT_LS : PTW_GNT_IF;
          addr_d  = sel_addr & ~(ADDR_W'(3));
          cnt_d   = '0;
          state_d = PTW_ST_ADDR;
        end
      end
      PTW_ST_ADDR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (timeout) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = PTW_ST_RESP;
        end else begin
          rd_req_o  = 1'b1;
          rd_addr_o = addr_q;
          if (rd_ready_i) state_d = PTW_ST_DATA;
        end
      end
      PTW_ST_DATA: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Data arriving on the timeout cycle takes precedence over the fault.
        if (rd_valid_i) begin
          data_d  = rd_data_i;
          err_d   = rd_err_i;
          state_d = PTW_ST_RESP;
        end else if (timeout) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = PTW_ST_RESP;
        end
      end
      PTW_ST_RESP: begin
        last_grant_d = gnt_q;
        state_d      = PTW_ST_IDLE;
        // A walker that dropped its request has been flushed; discard the data.
        if (gnt_req) begin
          if (gnt_q == PTW_GNT_IF) begin
            if_mem_rvalid_o = 1'b1;
            if_mem_rdata_o  = data_q;
            if_mem_fault_o  = err_q;
          end else begin
            ls_mem_rvalid_o = 1'b1;
            ls_mem_rdata_o  = data_q;
            ls_mem_fault_o  = err_q;
          end
        end
      end
      default: state_d = PTW_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PTW_ST_IDLE;
      gnt_q        <= PTW_GNT_IF;
      last_grant_q <= PTW_GNT_LS;
      cnt_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_ptw_mem_responder.sv
// Bench for ptw_mem_responder: vector table, directed multi-cycle sequences and
// a randomized run checked against a transaction-level reference model.
module tb_ptw_mem_responder;
  import ptw_mem_responder_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam logic [31:0] K = 32'hC3C3_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_mem_req_i, ls_mem_req_i;
  logic [AW-1:0] if_mem_addr_i, ls_mem_addr_i;
  logic [DW-1:0] if_mem_rdata_o, ls_mem_rdata_o;
  logic          if_mem_rvalid_o, if_mem_fault_o, ls_mem_rvalid_o, ls_mem_fault_o;
  logic          rd_req_o, rd_ready_i, rd_valid_i, rd_err_i;
  logic [AW-1:0] rd_addr_o;
  logic [DW-1:0] rd_data_i;
  logic [1:0]    dbg_state_o;

  int checks   = 0;
  int failures = 0;

  ptw_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .if_mem_req_i    (if_mem_req_i),
    .if_mem_addr_i   (if_mem_addr_i),
    .if_mem_rdata_o  (if_mem_rdata_o),
    .if_mem_rvalid_o (if_mem_rvalid_o),
    .if_mem_fault_o  (if_mem_fault_o),
    .ls_mem_req_i    (ls_mem_req_i),
    .ls_mem_addr_i   (ls_mem_addr_i),
    .ls_mem_rdata_o  (ls_mem_rdata_o),
    .ls_mem_rvalid_o (ls_mem_rvalid_o),
    .ls_mem_fault_o  (ls_mem_fault_o),
    .rd_req_o        (rd_req_o),
    .rd_addr_o       (rd_addr_o),
    .rd_ready_i      (rd_ready_i),
    .rd_valid_i      (rd_valid_i),
    .rd_data_i       (rd_data_i),
    .rd_err_i        (rd_err_i),
    .dbg_state_o     (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_mem_req_i  = 1'b0;
    if_mem_addr_i = '0;
    ls_mem_req_i  = 1'b0;
    ls_mem_addr_i = '0;
    rd_ready_i    = 1'b0;
    rd_valid_i    = 1'b0;
    rd_data_i     = '0;
    rd_err_i      = 1'b0;
  endtask

  // Ends at the drive point (posedge + 1) of the first post-reset cycle.
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] al(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

  // ---------------- vector table ----------------
  typedef struct {
    logic        port;      // 0 = IF, 1 = LS
    logic [31:0] addr;
    int          rw;        // cycles rd_ready_i is held low in ADDR
    int          vw;        // cycles after acceptance before rd_valid_i
    logic [31:0] data;
    logic        err;
    logic [31:0] exp_addr;
    int          exp_lat;   // cycle of rvalid, request sampled in cycle 0
    logic [31:0] exp_rdata;
    logic        exp_fault;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input int idx, input vec_t v);
    int   acc_c, val_c;
    logic req, exp_req, hit;
    acc_c = (1 + v.rw <= TO - 1) ? 1 + v.rw : -1;
    val_c = (acc_c >= 0) ? acc_c + 1 + v.vw : -1;
    req   = 1'b1;
    for (int c = 0; c <= v.exp_lat + 2; c++) begin
      if_mem_req_i  = req && (v.port == 1'b0);
      ls_mem_req_i  = req && (v.port == 1'b1);
      if_mem_addr_i = v.addr;
      ls_mem_addr_i = v.addr;
      rd_ready_i    = (c >= 1 + v.rw);
      rd_valid_i    = (c == val_c);
      rd_data_i     = (c == val_c) ? v.data : $urandom;
      rd_err_i      = (c == val_c) ? v.err : 1'($urandom_range(0, 1));
      @(negedge clk);
      exp_req = (c >= 1) && (c <= 1 + v.rw) && (c <= TO - 1);
      hit     = (c == v.exp_lat);
      chk($sformatf("vec%0d_c%0d_rd_req", idx, c), rd_req_o, exp_req);
      if (exp_req) chk($sformatf("vec%0d_c%0d_rd_addr", idx, c), rd_addr_o, v.exp_addr);
      chk($sformatf("vec%0d_c%0d_if_rvalid", idx, c), if_mem_rvalid_o, hit && (v.port == 1'b0));
      chk($sformatf("vec%0d_c%0d_ls_rvalid", idx, c), ls_mem_rvalid_o, hit && (v.port == 1'b1));
      if (hit) begin
        chk($sformatf("vec%0d_rdata", idx), v.port ? ls_mem_rdata_o : if_mem_rdata_o, v.exp_rdata);
        chk($sformatf("vec%0d_fault", idx), v.port ? ls_mem_fault_o : if_mem_fault_o, v.exp_fault);
        req = 1'b0;
      end
      @(posedge clk); #1;
    end
  endtask

  // ---------------- scoreboard / random model state ----------------
  logic [32:0] exp_q[$];
  int          st, nst, mem_wait, addr_wait, served;
  logic        prev_idle, prev_if, prev_ls, last_srv, cur_port;
  logic [31:0] prev_if_addr, prev_ls_addr, cur_addr, if_a, ls_a, acc_addr;
  logic        if_pend, ls_pend, exp_req, acc_prev;
  logic [32:0] e;

  initial begin
    rst = 1'b1;
    idle_inputs();

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    chk("rst_rd_req", rd_req_o, 1'b0);
    chk("rst_rd_addr", rd_addr_o, 32'h0);
    chk("rst_if_rvalid", if_mem_rvalid_o, 1'b0);
    chk("rst_if_rdata", if_mem_rdata_o, 32'h0);
    chk("rst_if_fault", if_mem_fault_o, 1'b0);
    chk("rst_ls_rvalid", ls_mem_rvalid_o, 1'b0);
    chk("rst_ls_rdata", ls_mem_rdata_o, 32'h0);
    chk("rst_ls_fault", ls_mem_fault_o, 1'b0);
    chk("rst_state", dbg_state_o, PTW_ST_IDLE);
    @(posedge clk); #1;

    // ---- table-driven single transactions ----
    vecs[0] = '{1'b0, 32'h8000_1003, 0,  0, 32'h2000_0C01, 1'b0, 32'h8000_1000, 3, 32'h2000_0C01, 1'b0};
    vecs[1] = '{1'b1, 32'h1234_5678, 3,  0, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678, 6, 32'hDEAD_BEEF, 1'b1};
    vecs[2] = '{1'b0, 32'h0000_0FFE, 1,  2, 32'h0000_0001, 1'b0, 32'h0000_0FFC, 6, 32'h0000_0001, 1'b0};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 0,  6, 32'hA5A5_A5A5, 1'b0, 32'hFFFF_FFFC, 9, 32'hA5A5_A5A5, 1'b0};
    vecs[4] = '{1'b0, 32'h4000_0004, 0,  8, 32'h1111_1111, 1'b0, 32'h4000_0004, 9, 32'h0000_0000, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0010, 99, 0, 32'h2222_2222, 1'b0, 32'h0000_0010, 9, 32'h0000_0000, 1'b1};
    vecs[6] = '{1'b0, 32'h7FFF_FFF1, 6,  0, 32'h0BAD_F00D, 1'b1, 32'h7FFF_FFF0, 9, 32'h0BAD_F00D, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_0002, 0, 99, 32'h3333_3333, 1'b0, 32'h0000_0000, 9, 32'h0000_0000, 1'b1};
    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // ---- tie from reset: IF, LS, then LS, IF on the following ties ----
    do_reset();
    acc_prev = 1'b0;
    acc_addr = '0;
    for (int c = 0; c <= 17; c++) begin
      if_mem_req_i  = (c <= 11);
      if_mem_addr_i = (c <= 3) ? 32'h1000_0000 : 32'h1000_0104;
      ls_mem_req_i  = (c <= 15);
      ls_mem_addr_i = (c <= 7) ? 32'h2000_0008 : 32'h2000_0FFE;
      rd_ready_i    = 1'b1;
      rd_valid_i    = acc_prev;
      rd_data_i     = acc_addr ^ K;
      rd_err_i      = acc_addr[2];
      @(negedge clk);
      acc_prev = rd_req_o && rd_ready_i;
      if (acc_prev) acc_addr = rd_addr_o;
      exp_req = (c == 1) || (c == 5) || (c == 9) || (c == 13);
      chk($sformatf("tie_c%0d_rd_req", c), rd_req_o, exp_req);
      case (c)
        1:  chk("tie_addr_if0", rd_addr_o, 32'h1000_0000);
        5:  chk("tie_addr_ls0", rd_addr_o, 32'h2000_0008);
        9:  chk("tie_addr_if1", rd_addr_o, 32'h1000_0104);
        13: chk("tie_addr_ls1", rd_addr_o, 32'h2000_0FFC);
        default: ;
      endcase
      chk($sformatf("tie_c%0d_if_rvalid", c), if_mem_rvalid_o, (c == 3) || (c == 11));
      chk($sformatf("tie_c%0d_ls_rvalid", c), ls_mem_rvalid_o, (c == 7) || (c == 15));
      if (c == 3) begin
        chk("tie_if0_rdata", if_mem_rdata_o, al(32'h1000_0000) ^ K);
        chk("tie_if0_fault", if_mem_fault_o, 1'b0);
      end
      if (c == 11) begin
        chk("tie_if1_rdata", if_mem_rdata_o, al(32'h1000_0104) ^ K);
        chk("tie_if1_fault", if_mem_fault_o, 1'b1);
      end
      if (c == 15) chk("tie_ls1_rdata", ls_mem_rdata_o, al(32'h2000_0FFE) ^ K);
      @(posedge clk); #1;
    end
    idle_inputs();

    // ---- IF drops its request while in DATA: read completes, no rvalid ----
    do_reset();
    for (int c = 0; c <= 7; c++) begin
      if_mem_req_i  = (c < 3);
      if_mem_addr_i = 32'h3000_0020;
      rd_ready_i    = 1'b1;
      rd_valid_i    = (c == 4);
      rd_data_i     = 32'h1234_5678;
      @(negedge clk);
      chk($sformatf("abn_c%0d_rd_req", c), rd_req_o, c == 1);
      chk($sformatf("abn_c%0d_if_rvalid", c), if_mem_rvalid_o, 1'b0);
      chk($sformatf("abn_c%0d_ls_rvalid", c), ls_mem_rvalid_o, 1'b0);
      if (c == 5) chk("abn_resp_state", dbg_state_o, PTW_ST_RESP);
      if (c == 6) chk("abn_idle_state", dbg_state_o, PTW_ST_IDLE);
      @(posedge clk); #1;
    end
    idle_inputs();

    // ---- reset while in DATA, stray data afterwards, then a fresh request ----
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      rst           = (c == 2);
      if_mem_req_i  = (c <= 2) || (c >= 5 && c <= 8);
      if_mem_addr_i = (c <= 2) ? 32'h5000_0000 : 32'h5000_0044;
      rd_ready_i    = 1'b1;
      rd_valid_i    = (c == 3) || (c == 4) || (c == 7);
      rd_data_i     = (c == 7) ? 32'hCAFE_F00D : 32'hFFFF_FFFF;
      rd_err_i      = (c == 7) ? 1'b0 : 1'b1;
      @(negedge clk);
      chk($sformatf("rstd_c%0d_rd_req", c), rd_req_o, (c == 1) || (c == 6));
      chk($sformatf("rstd_c%0d_if_rvalid", c), if_mem_rvalid_o, c == 8);
      chk($sformatf("rstd_c%0d_ls_rvalid", c), ls_mem_rvalid_o, 1'b0);
      if (c == 3) begin
        chk("rstd_state", dbg_state_o, PTW_ST_IDLE);
        chk("rstd_rd_addr", rd_addr_o, 32'h0);
        chk("rstd_if_rdata", if_mem_rdata_o, 32'h0);
        chk("rstd_if_fault", if_mem_fault_o, 1'b0);
      end
      if (c == 6) chk("rstd_new_addr", rd_addr_o, 32'h5000_0044);
      if (c == 8) begin
        chk("rstd_new_rdata", if_mem_rdata_o, 32'hCAFE_F00D);
        chk("rstd_new_fault", if_mem_fault_o, 1'b0);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    idle_inputs();

    // ---- randomized run against a transaction-level model ----
    do_reset();
    st = 0; prev_idle = 1'b1; prev_if = 1'b0; prev_ls = 1'b0;
    prev_if_addr = '0; prev_ls_addr = '0; last_srv = 1'b1;
    if_pend = 1'b0; ls_pend = 1'b0; if_a = '0; ls_a = '0;
    mem_wait = 0; addr_wait = 0; served = 0; cur_port = 1'b0; cur_addr = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!if_pend && $urandom_range(0, 3) == 0) begin
        if_pend = 1'b1;
        if_a    = $urandom & 32'h7FFF_FFFF;
      end
      if (!ls_pend && $urandom_range(0, 3) == 0) begin
        ls_pend = 1'b1;
        ls_a    = $urandom | 32'h8000_0000;
      end
      if_mem_req_i  = if_pend;
      if_mem_addr_i = if_a;
      ls_mem_req_i  = ls_pend;
      ls_mem_addr_i = ls_a;
      rd_ready_i    = (addr_wait >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
      rd_valid_i    = 1'b0;
      rd_data_i     = $urandom;
      rd_err_i      = 1'($urandom_range(0, 1));
      if (st == 2) begin
        if (mem_wait == 0) begin
          rd_valid_i = 1'b1;
          exp_q.push_back({rd_err_i, rd_data_i});
        end else begin
          mem_wait--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        rd_valid_i = 1'b1;
      end

      @(negedge clk);
      nst = st;
      case (st)
        0: begin
          exp_req = prev_idle && (prev_if || prev_ls);
          chk("rnd_req_start", rd_req_o, exp_req);
          chk("rnd_idle_if_rvalid", if_mem_rvalid_o, 1'b0);
          chk("rnd_idle_ls_rvalid", ls_mem_rvalid_o, 1'b0);
          if (rd_req_o) begin
            if (prev_if && prev_ls) cur_port = ~last_srv;
            else                    cur_port = prev_ls;
            cur_addr = al(cur_port ? prev_ls_addr : prev_if_addr);
            chk("rnd_arb_addr", rd_addr_o, cur_addr);
            if (rd_ready_i) begin
              nst = 2; mem_wait = $urandom_range(0, 3); addr_wait = 0;
            end else begin
              nst = 1; addr_wait = 1;
            end
          end
        end
        1: begin
          chk("rnd_req_hold", rd_req_o, 1'b1);
          chk("rnd_addr_hold", rd_addr_o, cur_addr);
          chk("rnd_addr_if_rvalid", if_mem_rvalid_o, 1'b0);
          chk("rnd_addr_ls_rvalid", ls_mem_rvalid_o, 1'b0);
          if (rd_ready_i) begin
            nst = 2; mem_wait = $urandom_range(0, 3); addr_wait = 0;
          end else begin
            addr_wait++;
          end
        end
        2: begin
          chk("rnd_data_rd_req", rd_req_o, 1'b0);
          chk("rnd_data_if_rvalid", if_mem_rvalid_o, 1'b0);
          chk("rnd_data_ls_rvalid", ls_mem_rvalid_o, 1'b0);
          if (rd_valid_i) nst = 3;
        end
        default: begin
          chk("rnd_resp_rd_req", rd_req_o, 1'b0);
          chk("rnd_resp_if_rvalid", if_mem_rvalid_o, cur_port == 1'b0);
          chk("rnd_resp_ls_rvalid", ls_mem_rvalid_o, cur_port == 1'b1);
          if (exp_q.size() == 0) begin
            chk("rnd_resp_expected_entry", 32'd0, 32'd1);
          end else begin
            e = exp_q.pop_front();
            chk("rnd_resp_rdata", cur_port ? ls_mem_rdata_o : if_mem_rdata_o, e[31:0]);
            chk("rnd_resp_fault", cur_port ? ls_mem_fault_o : if_mem_fault_o, e[32]);
          end
          last_srv = cur_port;
          served++;
          if (cur_port == 1'b0) begin
            if ($urandom_range(0, 1) == 1) if_a = $urandom & 32'h7FFF_FFFF;
            else                           if_pend = 1'b0;
          end else begin
            if ($urandom_range(0, 1) == 1) ls_a = $urandom | 32'h8000_0000;
            else                           ls_pend = 1'b0;
          end
          nst = 0;
        end
      endcase
      prev_idle    = (st == 0) && !rd_req_o;
      prev_if      = if_mem_req_i;
      prev_ls      = ls_mem_req_i;
      prev_if_addr = if_mem_addr_i;
      prev_ls_addr = ls_mem_addr_i;
      st           = nst;
      @(posedge clk); #1;
    end
    chk("rnd_progress", served > 100, 1'b1);
    idle_inputs();

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
